// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment value encoder.
// Holds segment patterns ({dp,g,f,e,d,c,b,a}, active-low), FSM state and limits.
package seg_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    localparam int MAX_DISPLAY = 9999;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ENCODE
    } state_t;

endpackage

// File: rtl/seg_value_encoder_digit.sv
// seg_digit_decode: combinational BCD digit to 7-bit active-low pattern {g..a}.
// Ports: bcd (4-bit digit in), pattern (7-bit segments out; non-BCD codes blank).
module seg_digit_decode
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_BLANK[6:0];
        case (bcd)
            4'd0:    pattern = SEG_0[6:0];
            4'd1:    pattern = SEG_1[6:0];
            4'd2:    pattern = SEG_2[6:0];
            4'd3:    pattern = SEG_3[6:0];
            4'd4:    pattern = SEG_4[6:0];
            4'd5:    pattern = SEG_5[6:0];
            4'd6:    pattern = SEG_6[6:0];
            4'd7:    pattern = SEG_7[6:0];
            4'd8:    pattern = SEG_8[6:0];
            4'd9:    pattern = SEG_9[6:0];
            default: pattern = SEG_BLANK[6:0];
        endcase
    end

endmodule

// File: rtl/seg_value_encoder.sv
// Binary-to-seven-segment encoder: double-dabble to BCD, then registered patterns.
// Ports: clk, rst, load/value/dp_mask in; seg_out_1..4, busy, done, overflow out.
module seg_value_encoder
    import seg_pkg::*;
#(
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [13:0] value,
    input  logic [3:0]  dp_mask,
    output logic [7:0]  seg_out_1,
    output logic [7:0]  seg_out_2,
    output logic [7:0]  seg_out_3,
    output logic [7:0]  seg_out_4,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    state_t      state;
    state_t      state_next;
    logic [29:0] shreg;
    logic [29:0] adj;
    logic [3:0]  step;
    logic [3:0]  dp_r;
    logic        ovf_r;
    logic [6:0]  dec [4];
    logic [3:0]  zero;
    logic [3:0]  blank;
    logic        lead;
    logic [7:0]  enc [4];

    // BCD nibbles sit in shreg[29:14]; adjust each before the shift.
    always_comb begin
        adj = shreg;
        for (int i = 0; i < 4; i++) begin
            if (shreg[14+4*i +: 4] >= 4'd5) begin
                adj[14+4*i +: 4] = shreg[14+4*i +: 4] + 4'd3;
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_dig
        seg_digit_decode u_dec (
            .bcd     (shreg[14+4*g +: 4]),
            .pattern (dec[g])
        );
        assign zero[g] = (shreg[14+4*g +: 4] == 4'd0);
    end

    // Blanking propagates down from the thousands digit while digits are zero.
    always_comb begin
        lead     = BLANK_LZ;
        blank    = 4'b0000;
        for (int i = 3; i >= 1; i--) begin
            blank[i] = lead && zero[i];
            lead     = blank[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (ovf_r) begin
                enc[i] = {~dp_r[i], SEG_DASH[6:0]};
            end else if (blank[i]) begin
                enc[i] = {~dp_r[i], SEG_BLANK[6:0]};
            end else begin
                enc[i] = {~dp_r[i], dec[i]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (load) state_next = SHIFT;
            SHIFT:   if (step == 4'd13) state_next = ENCODE;
            ENCODE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= '0;
            step      <= '0;
            dp_r      <= '0;
            ovf_r     <= 1'b0;
            seg_out_1 <= SEG_BLANK;
            seg_out_2 <= SEG_BLANK;
            seg_out_3 <= SEG_BLANK;
            seg_out_4 <= SEG_BLANK;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        shreg <= {16'd0, value};
                        dp_r  <= dp_mask;
                        ovf_r <= (value > 14'(MAX_DISPLAY));
                        step  <= 4'd0;
                    end
                end
                SHIFT: begin
                    shreg <= adj << 1;
                    step  <= step + 4'd1;
                end
                ENCODE: begin
                    seg_out_1 <= enc[0];
                    seg_out_2 <= enc[1];
                    seg_out_3 <= enc[2];
                    seg_out_4 <= enc[3];
                    overflow  <= ovf_r;
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_value_encoder.sv
// Self-checking bench for seg_value_encoder with and without leading-zero blanking.
// Expected patterns come from a decimal model queued at load time.
module tb_seg_value_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [13:0] value = '0;
    logic [3:0]  dp_mask = '0;
    logic [7:0]  s1, s2, s3, s4;
    logic [7:0]  z1, z2, z3, z4;
    logic        busy, done, overflow;
    logic        busy0, done0, overflow0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] s1;
        logic [31:0] s0;
        logic        ovf;
        int          due;
    } entry_t;

    entry_t sb[$];
    entry_t me;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seg_value_encoder #(.BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_mask(dp_mask),
        .seg_out_1(s1), .seg_out_2(s2), .seg_out_3(s3), .seg_out_4(s4),
        .busy(busy), .done(done), .overflow(overflow)
    );

    seg_value_encoder #(.BLANK_LZ(1'b0)) dut0 (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_mask(dp_mask),
        .seg_out_1(z1), .seg_out_2(z2), .seg_out_3(z3), .seg_out_4(z4),
        .busy(busy0), .done(done0), .overflow(overflow0)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            default: return 8'h90;
        endcase
    endfunction

    function automatic logic [31:0] model(input int v, input logic [3:0] dp,
                                          input bit lz);
        logic [7:0] p [4];
        int dg [4];
        bit lead;
        dg[0] = v % 10;
        dg[1] = (v / 10) % 10;
        dg[2] = (v / 100) % 10;
        dg[3] = (v / 1000) % 10;
        lead = lz;
        for (int i = 3; i >= 0; i--) begin
            if (v > 9999) p[i] = 8'hBF;
            else if (lead && i != 0 && dg[i] == 0) p[i] = 8'hFF;
            else begin
                p[i] = pat(dg[i]);
                lead = 1'b0;
            end
            if (dp[i]) p[i][7] = 1'b0;
        end
        return {p[3], p[2], p[1], p[0]};
    endfunction

    // Caller is at a negedge; load is sampled on the next posedge.
    task automatic do_load(input int v, input logic [3:0] m, input bit push);
        entry_t e;
        load = 1'b1;
        value = v[13:0];
        dp_mask = m;
        @(posedge clk);
        #1;
        if (push) begin
            e.s1 = model(v, m, 1'b1);
            e.s0 = model(v, m, 1'b0);
            e.ovf = (v > 9999);
            e.due = cyc + 15;
            sb.push_back(e);
        end
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (!rst && (done === 1'b1 || done0 === 1'b1)) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                me = sb.pop_front();
                check("seg_lz1", {s4, s3, s2, s1}, me.s1);
                check("seg_lz0", {z4, z3, z2, z1}, me.s0);
                check("done_lz0", {31'd0, done0}, 32'd1);
                check("overflow", {31'd0, overflow}, {31'd0, me.ovf});
                check("overflow_lz0", {31'd0, overflow0}, {31'd0, me.ovf});
                check("latency", cyc, me.due);
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_seg", {s4, s3, s2, s1}, 32'hFFFF_FFFF);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);

        do_load(1234, 4'b0000, 1'b1);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", n, 15);
        check("done_after_busy", {31'd0, done}, 32'd1);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);

        @(negedge clk);
        do_load(7, 4'b0010, 1'b1);
        wait_done("done_7");

        @(negedge clk);
        do_load(9999, 4'b0000, 1'b1);
        wait_done("done_9999");
        do_load(10000, 4'b0000, 1'b1);
        wait_done("done_10000");
        @(negedge clk);
        do_load(16383, 4'b1001, 1'b1);
        wait_done("done_16383");

        @(negedge clk);
        do_load(300, 4'b0000, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_seg", {s4, s3, s2, s1}, 32'hFFFF_FFFF);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_ovf", {31'd0, overflow}, 32'd0);
        repeat (25) @(negedge clk);
        check("midrst_idle", {31'd0, busy}, 32'd0);

        do_load(42, 4'b0000, 1'b1);
        repeat (4) @(negedge clk);
        do_load(5, 4'b0000, 1'b0);
        wait_done("done_42");
        repeat (20) @(negedge clk);
        check("seg_hold", {s4, s3, s2, s1}, 32'hFFFF_99A4);

        do_load(0, 4'b0000, 1'b1);
        wait_done("done_0");
        @(negedge clk);
        do_load(1234, 4'b0101, 1'b1);
        wait_done("done_1234b");

        repeat (20) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
